sevenseg_bcd_display: RTL



---
 rtl/sevenseg_pkg.sv | 51 +++++
 rtl/sevenseg_hex_digit.sv | 18 +
 rtl/sevenseg_bcd_display.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_pkg
// Shared definitions for the seven-segment BCD display driver.
//   - SEG_BLANK / SEG_DASH / SEG_ZERO : special active-low gfedcba patterns
//   - SEG_TABLE                       : 16-entry glyph table for 0-F
//   - state_t                         : controller states (IDLE, SHIFT, UPDATE)
//   - pow10()                         : constant helper for the decimal range
// ---------------------------------------------------------------------------
package sevenseg_pkg;

    // Active-low, bit order gfedcba (bit 6 = g, bit 0 = a).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // 10**n as a 64-bit constant; n is at most 8 here so no overflow.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_hex_digit.sv
// ---------------------------------------------------------------------------
// sevenseg_hex_digit
// Combinational 4-bit to seven-segment decoder covering 0-F.
// Ports:
//   nibble_i [3:0] : digit value to decode
//   seg_o    [6:0] : active-low segment code, bit order gfedcba
// Blank/dash overrides are applied by the parent, not here.
// ---------------------------------------------------------------------------
module sevenseg_hex_digit
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/sevenseg_bcd_display.sv
// ---------------------------------------------------------------------------
// sevenseg_bcd_display
// Multi-digit static seven-segment driver. A binary value is accepted on
// load; in decimal mode it is converted to BCD by a shift-add-3 (double
// dabble) sequence, one input bit per clock; in hex mode its nibbles are
// shown directly. The segment outputs are registered and change only in the
// UPDATE state (or on reset), so the display never shows partial results.
//
// Parameters:
//   DIGITS (1..8)  number of digits driven
//   WIDTH  (4..32) width of the binary input
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   load       display request, sampled only while busy = 0
//   value      binary value, captured on an accepted load
//   hex_mode   1 = hex digits, 0 = decimal; captured with value
//   busy       high while state is not IDLE
//   valid      one-cycle pulse in the first cycle new segments are shown
//   overflow   high while the displayed value does not fit in DIGITS digits
//   segments   7*DIGITS active-low codes, digit 0 in segments[6:0]
//
// Build option: define SEVENSEG_LEADING_ZERO_BLANK_EN to blank zero digits
// above the most significant nonzero digit (digit 0 always shown).
//
// Handshake: load is a request qualified by !busy. An accepted load raises
// busy on the next cycle; busy drops in the same cycle valid pulses. A load
// seen while busy is dropped, not queued; a load held high is taken again
// on the first IDLE cycle.
// ---------------------------------------------------------------------------
module sevenseg_bcd_display
    import sevenseg_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int WIDTH  = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  hex_mode,
    output logic                  busy,
    output logic                  valid,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int          NB      = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(WIDTH + 1);
    localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    // Pattern shown after reset: a single "0", or all "0"s without blanking.
    function automatic logic [7*DIGITS-1:0] reset_pattern();
        logic [7*DIGITS-1:0] p;
        for (int i = 0; i < DIGITS; i++) begin
            p[7*i +: 7] = (LZ_BLANK && (i != 0)) ? SEG_BLANK : SEG_ZERO;
        end
        return p;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_RESET = reset_pattern();

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state_q,    state_d;
    logic [WIDTH-1:0]     shreg_q,    shreg_d;     // value bits, MSB first
    logic [NB-1:0]        bcd_q,      bcd_d;       // BCD digits or hex nibbles
    logic [CNT_W-1:0]     cnt_q,      cnt_d;       // shifts done so far
    logic                 hex_q,      hex_d;
    logic                 ovf_pend_q, ovf_pend_d;  // overflow of the pending value
    logic                 ovf_q,      ovf_d;       // overflow of the shown value
    logic                 valid_q,    valid_d;
    logic [7*DIGITS-1:0]  seg_q,      seg_d;

    // -----------------------------------------------------------------------
    // Range checks on the incoming value
    // -----------------------------------------------------------------------
    logic [63:0] val_ext;
    logic        dec_ovf;
    logic        hex_ovf;

    assign val_ext = 64'(value);
    assign dec_ovf = (val_ext > DEC_MAX);
    assign hex_ovf = |(val_ext >> NB);

    // -----------------------------------------------------------------------
    // Double-dabble correction: every BCD digit >= 5 gets +3 before the
    // shift, so that a digit reaching 10 carries into the next digit.
    // Only the low DIGITS digits are kept; a value that needs more digits is
    // flagged as overflow and shown as dashes, so the lost carries never
    // reach the display.
    // -----------------------------------------------------------------------
    logic [NB-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-digit glyphs and the override muxing (dash / leading blank)
    // -----------------------------------------------------------------------
    logic [6:0] dig_seg [DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        sevenseg_hex_digit u_dec (
            .nibble_i (bcd_q[4*g +: 4]),
            .seg_o    (dig_seg[g])
        );
    end

    // lz[i] = digits i..DIGITS-1 are all zero.
    logic [DIGITS:0]      lz;
    logic [7*DIGITS-1:0]  seg_new;

    always_comb begin
        lz         = '0;
        lz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz[i] = lz[i+1] & (bcd_q[4*i +: 4] == 4'd0);
        end

        seg_new = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_pend_q && !hex_q) begin
                seg_new[7*i +: 7] = SEG_DASH;
            end else if (LZ_BLANK && (i != 0) && lz[i]) begin
                seg_new[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_new[7*i +: 7] = dig_seg[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Controller: next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        hex_d      = hex_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        seg_d      = seg_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    hex_d = hex_mode;
                    if (hex_mode) begin
                        // Nibbles are already the digits; missing upper
                        // nibbles come in as zero from the extension.
                        bcd_d      = val_ext[NB-1:0];
                        ovf_pend_d = hex_ovf;
                        state_d    = UPDATE;
                    end else begin
                        shreg_d    = value;
                        bcd_d      = '0;
                        cnt_d      = '0;
                        ovf_pend_d = dec_ovf;
                        state_d    = SHIFT;
                    end
                end
            end

            SHIFT: begin
                bcd_d   = {bcd_adj[NB-2:0], shreg_q[WIDTH-1]};
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                seg_d   = seg_new;
                ovf_d   = ovf_pend_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            hex_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            seg_q      <= SEG_RESET;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            hex_q      <= hex_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            seg_q      <= seg_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign segments = seg_q;

endmodule
